rggen_handshake_register_common: RTL



---
 rtl/rggen_handshake_register_common_pkg.sv | 24 ++
 rtl/rggen_handshake_register_common_if.sv | 46 ++++
 rtl/rggen_address_decoder.sv | 27 ++
 rtl/rggen_handshake_register_common_controller.sv | 49 ++++
 rtl/rggen_mux.sv | 16 +
 rtl/rggen_handshake_register_common.sv | 151 +++++++++++++++
 6 files changed

// File: rtl/rggen_handshake_register_common_pkg.sv
// Shared status/access codes and handshake FSM state type for the
// multi-cycle register front-end.
package rggen_handshake_register_common_pkg;
    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    // access[DATA_BIT] = 1 means write; code 2'b00 is never issued by the bus adapter
    localparam int RGGEN_ACCESS_DATA_BIT      = 0;
    localparam int RGGEN_ACCESS_NONPOSTED_BIT = 1;

    localparam logic [1:0] RGGEN_POSTED_WRITE = 2'b01;
    localparam logic [1:0] RGGEN_READ         = 2'b10;
    localparam logic [1:0] RGGEN_WRITE        = 2'b11;

    typedef enum logic [1:0] {
        RGGEN_HANDSHAKE_IDLE    = 2'd0,
        RGGEN_HANDSHAKE_WAIT    = 2'd1,
        RGGEN_HANDSHAKE_RESPOND = 2'd2
    } rggen_handshake_state_e;
endpackage

// File: rtl/rggen_handshake_register_common_if.sv
// Bus-side (register) and bit-field-side interfaces of a register front-end.
interface rggen_register_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int VALUE_WIDTH   = BUS_WIDTH
);
    logic                                             valid;
    logic [1:0]                                       access;
    logic [ADDRESS_WIDTH-1:0]                         address;
    logic [BUS_WIDTH-1:0]                             write_data;
    logic [BUS_WIDTH/8-1:0]                           strobe;
    logic                                             active;
    logic                                             ready;
    rggen_handshake_register_common_pkg::rggen_status status;
    logic [BUS_WIDTH-1:0]                             read_data;
    logic [VALUE_WIDTH-1:0]                           value;

    modport master (
        output valid, access, address, write_data, strobe,
        input  active, ready, status, read_data, value
    );
    modport register (
        input  valid, access, address, write_data, strobe,
        output active, ready, status, read_data, value
    );
endinterface

interface rggen_bit_field_if #(
    parameter int WIDTH = 32
);
    logic             read_valid;
    logic             write_valid;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] value;

    modport register (
        output read_valid, write_valid, mask, write_data,
        input  read_data, value
    );
    modport bit_field (
        input  read_valid, write_valid, mask, write_data,
        output read_data, value
    );
endinterface

// File: rtl/rggen_address_decoder.sv
// Single-word address decoder: aligned address compare qualified by access
// direction and an optional external match.
module rggen_address_decoder #(
    parameter bit               READABLE             = 1'b1,
    parameter bit               WRITABLE             = 1'b1,
    parameter int               WIDTH                = 8,
    parameter int               LSB                  = 2,
    parameter bit [WIDTH-1:0]   ADDRESS              = '0,
    parameter bit               USE_ADDITIONAL_MATCH = 1'b0
)(
    input  logic [WIDTH-1:0] i_address,
    input  logic             i_write,
    input  logic             i_additional_match,
    output logic             o_match
);
    // byte-lane bits below LSB never take part in the compare
    localparam bit [WIDTH-1:0] ALIGN_MASK = ~((WIDTH'(1) << LSB) - WIDTH'(1));

    logic address_match;
    logic access_match;
    logic additional_match;

    assign address_match    = (i_address & ALIGN_MASK) == (ADDRESS & ALIGN_MASK);
    assign access_match     = i_write ? WRITABLE : READABLE;
    assign additional_match = !USE_ADDITIONAL_MATCH || i_additional_match;
    assign o_match          = address_match && access_match && additional_match;
endmodule

// File: rtl/rggen_handshake_register_common_controller.sv
// Handshake FSM (IDLE -> WAIT -> RESPOND) with a saturating wait counter
// that produces the timeout flag.
module rggen_handshake_register_common_controller
    import rggen_handshake_register_common_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
)(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_request,
    input  logic                   i_bit_field_ready,
    output rggen_handshake_state_e o_state,
    output logic                   o_capture_request,
    output logic                   o_capture_response,
    output logic                   o_timeout
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;
    localparam int COUNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [1:0]         state;
    logic [COUNT_W-1:0] count;

    assign o_state            = rggen_handshake_state_e'(state);
    assign o_capture_request  = (state == IDLE) && i_request;
    // count is 0 in the first WAIT cycle, so it fires in WAIT cycle TIMEOUT_CYCLES
    assign o_timeout          = (TIMEOUT_CYCLES != 0) && (state == WAIT) &&
                                (count == COUNT_W'(TIMEOUT_CYCLES - 1));
    assign o_capture_response = (state == WAIT) && (i_bit_field_ready || o_timeout);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE:    if (i_request) state <= WAIT;
                WAIT:    if (i_bit_field_ready || o_timeout) state <= RESPOND;
                default: state <= IDLE;
            endcase
            if (state != WAIT) begin
                count <= '0;
            end else if (count != COUNT_W'(TIMEOUT_CYCLES)) begin
                count <= count + COUNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/rggen_mux.sv
// One-hot AND-OR multiplexer.
module rggen_mux #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 2
)(
    input  logic [ENTRIES-1:0]            i_select,
    input  logic [ENTRIES-1:0][WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]              o_data
);
    always_comb begin
        o_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            o_data |= i_data[i] & {WIDTH{i_select[i]}};
        end
    end
endmodule

// File: rtl/rggen_handshake_register_common.sv
// Register front-end that holds a captured bus request on the bit-field side
// until the bit fields acknowledge (or time out), then returns a registered response.
module rggen_handshake_register_common
    import rggen_handshake_register_common_pkg::*;
#(
    parameter bit                     READABLE             = 1'b1,
    parameter bit                     WRITABLE             = 1'b1,
    parameter int                     ADDRESS_WIDTH        = 8,
    parameter bit [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS       = '0,
    parameter int                     BUS_WIDTH            = 32,
    parameter int                     DATA_WIDTH           = BUS_WIDTH,
    parameter int                     VALUE_WIDTH          = BUS_WIDTH,
    parameter bit                     USE_ADDITIONAL_MATCH = 1'b0,
    parameter int                     TIMEOUT_CYCLES       = 0
)(
    input logic                 i_clk,
    input logic                 i_rst_n,
    rggen_register_if.register  register_if,
    input logic                 i_additional_match,
    rggen_bit_field_if.register bit_field_if,
    input logic                 i_bit_field_ready,
    input logic                 i_bit_field_error
);
    localparam int WORDS     = DATA_WIDTH / BUS_WIDTH;
    localparam int BUS_BYTES = BUS_WIDTH / 8;
    localparam int LSB       = $clog2(BUS_BYTES);

    logic [WORDS-1:0]       match;
    logic [WORDS-1:0]       match_q;
    logic                   active;
    logic                   is_write;
    logic                   write_q;
    logic [BUS_WIDTH-1:0]   strobe_bits;
    logic [DATA_WIDTH-1:0]  mask_next;
    logic [DATA_WIDTH-1:0]  write_data_next;
    logic [DATA_WIDTH-1:0]  mask_q;
    logic [DATA_WIDTH-1:0]  write_data_q;
    logic [BUS_WIDTH-1:0]   selected_data;
    logic [BUS_WIDTH-1:0]   read_data_q;
    rggen_status            status_q;
    rggen_handshake_state_e state;
    logic                   capture_request;
    logic                   capture_response;
    logic                   timeout;

    assign is_write = register_if.access[RGGEN_ACCESS_DATA_BIT];

    for (genvar g = 0; g < WORDS; g++) begin : g_decoder
        rggen_address_decoder #(
            .READABLE             (READABLE),
            .WRITABLE             (WRITABLE),
            .WIDTH                (ADDRESS_WIDTH),
            .LSB                  (LSB),
            .ADDRESS              (ADDRESS_WIDTH'(OFFSET_ADDRESS + g * BUS_BYTES)),
            .USE_ADDITIONAL_MATCH (USE_ADDITIONAL_MATCH)
        ) u_decoder (
            .i_address          (register_if.address),
            .i_write            (is_write),
            .i_additional_match (i_additional_match),
            .o_match            (match[g])
        );
    end

    assign active = |match;

    rggen_handshake_register_common_controller #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_controller (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_request          (register_if.valid && active),
        .i_bit_field_ready  (i_bit_field_ready),
        .o_state            (state),
        .o_capture_request  (capture_request),
        .o_capture_response (capture_response),
        .o_timeout          (timeout)
    );

    always_comb begin
        strobe_bits = '0;
        for (int i = 0; i < BUS_BYTES; i++) begin
            strobe_bits[8*i+:8] = {8{register_if.strobe[i]}};
        end
    end

    always_comb begin
        mask_next       = '0;
        write_data_next = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (match[w]) mask_next[w*BUS_WIDTH+:BUS_WIDTH] = strobe_bits;
            if (WRITABLE) write_data_next[w*BUS_WIDTH+:BUS_WIDTH] = register_if.write_data;
        end
    end

    // request capture: IDLE -> WAIT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            match_q      <= '0;
            write_q      <= 1'b0;
            mask_q       <= '0;
            write_data_q <= '0;
        end else if (capture_request) begin
            match_q      <= match;
            write_q      <= is_write;
            mask_q       <= mask_next;
            write_data_q <= write_data_next;
        end
    end

    rggen_mux #(
        .WIDTH   (BUS_WIDTH),
        .ENTRIES (WORDS)
    ) u_read_mux (
        .i_select (match_q),
        .i_data   (bit_field_if.read_data),
        .o_data   (selected_data)
    );

    // response capture: WAIT -> RESPOND; a ready in the timeout cycle wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            read_data_q <= '0;
            status_q    <= RGGEN_OKAY;
        end else if (capture_response) begin
            if (i_bit_field_ready) begin
                read_data_q <= write_q ? '0 : selected_data;
                status_q    <= i_bit_field_error ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
            end else begin
                read_data_q <= '0;
                status_q    <= RGGEN_SLAVE_ERROR;
            end
        end
    end

    assign register_if.active    = active;
    assign register_if.ready     = state == RGGEN_HANDSHAKE_RESPOND;
    assign register_if.status    = status_q;
    assign register_if.read_data = read_data_q;
    assign register_if.value     = VALUE_WIDTH'(bit_field_if.value);

    assign bit_field_if.read_valid  = (state == RGGEN_HANDSHAKE_WAIT) && !timeout && !write_q;
    assign bit_field_if.write_valid = (state == RGGEN_HANDSHAKE_WAIT) && !timeout && write_q;
    assign bit_field_if.mask        = mask_q;
    assign bit_field_if.write_data  = write_data_q;

    // at most one word may decode; a miss leaves match all-zero
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        register_if.valid |-> $onehot0(match));
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        register_if.valid |-> (register_if.access != 2'b00));
endmodule
